// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with selectable first-word-fall-through or registered read,
// occupancy level, almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_flex #(
    parameter int ADDR_WIDTH    = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  walmost_full,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_L  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_L = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   level_q;
    logic                  wa;
    logic                  ra;

    // Handshake: a word is written when wen=1 and wfull=0 at a clk edge, and
    // popped when ren=1 and rempty=0; requests against full/empty are dropped.
    assign wa = wen & ~wfull;
    assign ra = ren & ~rempty;

    // Full/empty come only from the level register; pointers wrap freely.
    assign level         = level_q;
    assign wfull         = (level_q == DEPTH_L);
    assign rempty        = (level_q == '0);
    assign walmost_full  = (level_q >= AFULL_L);
    assign ralmost_empty = (level_q <= AEMPTY_L);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            if (wa) wptr <= wptr + PTR_ONE;
            if (ra) rptr <= rptr + PTR_ONE;
            case ({wa, ra})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wa && !reset) mem[wptr] <= wdata;
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wen && wfull)  overflow <= 1'b1;
            else if (err_clr)  overflow <= 1'b0;
            if (ren && rempty) underflow <= 1'b1;
            else if (err_clr)  underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata  = mem[rptr];
            assign rvalid = ~rempty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  rvalid_q;

            // rdata holds its last word while no read is accepted.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= ra;
                    if (ra) rdata_q <= mem[rptr];
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: an FWFT and a registered-read instance share one
// stimulus stream and are checked against a queue-based reference model.
module tb_sync_fifo_flex;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       wen;
    logic       ren;
    logic       err_clr;
    logic [7:0] wdata;

    logic       f_wfull, f_walmost_full, f_rvalid, f_rempty, f_ralmost_empty;
    logic       f_overflow, f_underflow;
    logic [7:0] f_rdata;
    logic [3:0] f_level;
    logic       r_wfull, r_walmost_full, r_rvalid, r_rempty, r_ralmost_empty;
    logic       r_overflow, r_underflow;
    logic [7:0] r_rdata;
    logic [3:0] r_level;

    // Reference model state
    logic [7:0] ref_q[$];
    logic [7:0] exp_f[$];
    logic [7:0] exp_r[$];
    logic       ovf_m, unf_m, rv_m;
    logic [7:0] last_rd_m;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.FWFT(1)) dut_f (
        .clk(clk), .reset(reset), .wen(wen), .wdata(wdata),
        .wfull(f_wfull), .walmost_full(f_walmost_full), .ren(ren),
        .rdata(f_rdata), .rvalid(f_rvalid), .rempty(f_rempty),
        .ralmost_empty(f_ralmost_empty), .level(f_level),
        .overflow(f_overflow), .underflow(f_underflow), .err_clr(err_clr)
    );

    sync_fifo_flex #(.FWFT(0)) dut_r (
        .clk(clk), .reset(reset), .wen(wen), .wdata(wdata),
        .wfull(r_wfull), .walmost_full(r_walmost_full), .ren(ren),
        .rdata(r_rdata), .rvalid(r_rvalid), .rempty(r_rempty),
        .ralmost_empty(r_ralmost_empty), .level(r_level),
        .overflow(r_overflow), .underflow(r_underflow), .err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered state after the last edge versus the model.
    task automatic check_state();
        int n;
        n = ref_q.size();
        chk("f_level", 32'(f_level), 32'(n));
        chk("r_level", 32'(r_level), 32'(n));
        chk("f_rempty", 32'(f_rempty), 32'(n == 0));
        chk("r_rempty", 32'(r_rempty), 32'(n == 0));
        chk("f_wfull", 32'(f_wfull), 32'(n == DEPTH));
        chk("r_wfull", 32'(r_wfull), 32'(n == DEPTH));
        chk("f_walmost_full", 32'(f_walmost_full), 32'(n >= 6));
        chk("r_walmost_full", 32'(r_walmost_full), 32'(n >= 6));
        chk("f_ralmost_empty", 32'(f_ralmost_empty), 32'(n <= 1));
        chk("r_ralmost_empty", 32'(r_ralmost_empty), 32'(n <= 1));
        chk("f_overflow", 32'(f_overflow), 32'(ovf_m));
        chk("r_overflow", 32'(r_overflow), 32'(ovf_m));
        chk("f_underflow", 32'(f_underflow), 32'(unf_m));
        chk("r_underflow", 32'(r_underflow), 32'(unf_m));
        chk("f_rvalid", 32'(f_rvalid), 32'(n != 0));
        if (n != 0) chk("f_rdata_head", 32'(f_rdata), 32'(ref_q[0]));
        chk("r_rvalid", 32'(r_rvalid), 32'(rv_m));
        chk("r_rdata_held", 32'(r_rdata), 32'(last_rd_m));
    endtask

    task automatic step(input logic r, input logic w, input logic rd,
                        input logic [7:0] d, input logic ec);
        logic       full, empty;
        logic [7:0] x;
        check_state();
        reset = r; wen = w; ren = rd; wdata = d; err_clr = ec;
        if (r) begin
            ref_q.delete();
            ovf_m = 1'b0; unf_m = 1'b0; rv_m = 1'b0; last_rd_m = 8'h00;
        end else begin
            full  = (ref_q.size() == DEPTH);
            empty = (ref_q.size() == 0);
            if (w && full)      ovf_m = 1'b1;
            else if (ec)        ovf_m = 1'b0;
            if (rd && empty)    unf_m = 1'b1;
            else if (ec)        unf_m = 1'b0;
            rv_m = rd && !empty;
            if (rd && !empty) begin
                x = ref_q.pop_front();
                exp_f.push_back(x);
                exp_r.push_back(x);
                last_rd_m = x;
            end
            if (w && !full) ref_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected words whenever a DUT presents a read word.
    initial begin
        forever begin
            @(negedge clk);
            if (f_rvalid && ren && !reset) begin
                chk("f_pop_expected", 32'(exp_f.size() != 0), 32'd1);
                if (exp_f.size() != 0) chk("f_pop_data", 32'(f_rdata), 32'(exp_f.pop_front()));
            end
            if (r_rvalid) begin
                chk("r_pop_expected", 32'(exp_r.size() != 0), 32'd1);
                if (exp_r.size() != 0) chk("r_pop_data", 32'(r_rdata), 32'(exp_r.pop_front()));
            end
        end
    end

    initial begin
        int wp;
        reset = 1'b1; wen = 1'b0; ren = 1'b0; wdata = 8'h00; err_clr = 1'b0;
        ovf_m = 1'b0; unf_m = 1'b0; rv_m = 1'b0; last_rd_m = 8'h00;
        @(posedge clk);
        #1;
        step(1, 0, 0, 8'h00, 0);

        // Fill with 0x10..0x17, then drain
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h10 + i), 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00, 0);

        // Simultaneous write/read on full, then error clear
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h10 + i), 0);
        step(0, 1, 1, 8'hAA, 0);
        step(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h00, 0);

        // Simultaneous write/read on empty
        step(0, 1, 1, 8'h55, 0);
        step(0, 0, 1, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1);

        // Three words, then four reads (last one underflows)
        for (int i = 1; i <= 3; i++) step(0, 1, 0, 8'(i), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1);

        // Sustained write+read at level 3 across pointer wraps
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'h40 + i), 0);
        for (int i = 3; i < 23; i++) step(0, 1, 1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00, 0);

        // Reset mid-operation with wen high
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h60 + i), 0);
        step(0, 1, 0, 8'hFF, 0);
        step(0, 0, 1, 8'h00, 0);
        step(1, 1, 0, 8'hEE, 0);
        step(0, 1, 0, 8'h77, 0);
        step(0, 0, 1, 8'h00, 0);

        // Random traffic with alternating write- and read-heavy phases
        for (int i = 0; i < 400; i++) begin
            wp = ((i / 50) % 2 == 0) ? 75 : 25;
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 100 - wp) ? 1'b1 : 1'b0,
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);
        chk("exp_f_drained", 32'(exp_f.size()), 32'd0);
        chk("exp_r_drained", 32'(exp_r.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised FIFO; next generation of the team's FIFO family, for use inside one clock domain.
- Adds to the existing FIFOs:
  - selectable read mode: first-word-fall-through or registered read;
  - occupancy level output;
  - almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags.
- Storage is an internal register array. Read and write pointers are plain binary, with no gray coding.

Parameters:
- ADDR_WIDTH, 3: log2 of depth; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 8: width of each word.
- FWFT, 1: read mode.
  - 1 = head word is visible on rdata whenever rvalid is high.
  - 0 = registered read with 1-cycle latency after an accepted ren.
- AFULL_THRESH, 6: walmost_full is asserted when level >= AFULL_THRESH. Legal range 1..DEPTH.
- AEMPTY_THRESH, 1: ralmost_empty is asserted when level <= AEMPTY_THRESH. Legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- wen  input  1  write request.
- wdata  input  DATA_WIDTH  write data.
- wfull  output  1  level == DEPTH.
- walmost_full  output  1  level >= AFULL_THRESH.
- ren  input  1  read request, or pop in FWFT mode.
- rdata  output  DATA_WIDTH  read data.
- rvalid  output  1  rdata valid.
- rempty  output  1  level == 0.
- ralmost_empty  output  1  level <= AEMPTY_THRESH.
- level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while wfull.
- underflow  output  1  sticky: a read was attempted while rempty.
- err_clr  input  1  clears overflow and underflow.

Behaviour:
- Reset is synchronous, active-high. When reset is high at a clk edge:
  - wptr, rptr and level go to 0;
  - overflow and underflow go to 0;
  - in FWFT=0 mode, rdata goes to 0 and rvalid goes to 0.
- Output values after reset:
  - rempty=1, wfull=0, ralmost_empty=1;
  - walmost_full=0, since AFULL_THRESH >= 1.
- Memory contents are not reset.
- Reset mid-operation discards all stored data. Any wen or ren in the reset cycle is ignored.
- Accept rules are evaluated on registered state at the edge:
  - write accepted: wa = wen & ~wfull;
  - read accepted: ra = ren & ~rempty.
- Accepted write: mem[wptr] <= wdata; wptr increments, wrapping DEPTH-1 -> 0.
- Accepted read: rptr increments, with the same wrap.
- Level update:
  - wa & ~ra: level+1;
  - ra & ~wa: level-1;
  - both or neither: level unchanged.
- Simultaneous wen and ren:
  - When full: the read is accepted and the write is dropped. overflow is set. Level goes to DEPTH-1.
  - When empty: the write is accepted and the read is dropped. underflow is set. Level goes to 1.
  - Otherwise both are accepted and level is unchanged.
- All flags are combinational decodes of the level register, so each flag reflects an operation one cycle after its edge.
- No pass-through in either mode: a word written at edge N is readable no earlier than the cycle after edge N.
- FWFT=1:
  - rdata = mem[rptr] (combinational), and rvalid = ~rempty.
  - rdata is don't-care when rvalid=0.
  - ren with rvalid=1 pops the displayed word; the next word appears in the following cycle.
- FWFT=0:
  - On ra, rdata <= mem[rptr] and rvalid <= 1 at the same edge. The data is visible the cycle after ren.
  - With no ra, rvalid <= 0 and rdata holds its last value.
  - Back-to-back ren gives one word per cycle.
- Sticky errors:
  - overflow <= 1 on wen & wfull; underflow <= 1 on ren & rempty.
  - Each remains set until err_clr or reset.
  - If err_clr and a new error occur in the same cycle, set wins.
- Errors never corrupt pointers, level or memory.
- Wrap-around: pointer wrap is transparent. Full versus empty is decided only by level, never by pointer compare.

Test Plan:
- Defaults (FWFT=1, DEPTH=8). Reset, then write 8 words 0x10..0x17 with no reads:
  - after the 1st write: level=1, rempty=0, ralmost_empty=1;
  - after the 2nd write: ralmost_empty=0;
  - after the 6th write: walmost_full=1;
  - after the 8th write: wfull=1, level=8, rdata=0x10.
  - Then pop 8: rdata sequence 0x10..0x17, ending with rempty=1 and rvalid=0.
- Full FIFO, wen=1 and ren=1 in one cycle with wdata=0xAA: 0x10 is popped, 0xAA is not stored, overflow=1, level=7. Next cycle, err_clr=1 -> overflow=0.
- Empty FIFO, wen=1 and ren=1 with wdata=0x55: 0x55 is stored, underflow=1, level=1. Next cycle: rdata=0x55, rvalid=1.
- FWFT=0. Write 0x01, 0x02, 0x03, then ren for 3 consecutive cycles:
  - rvalid is high for the 3 cycles following the first ren;
  - rdata = 0x01, 0x02, 0x03;
  - a 4th ren sets underflow and rvalid=0, with rdata held at 0x03.
- Wrap: sustain simultaneous wen and ren for 20 cycles at level=3 with an incrementing pattern. Level stays 3 and the read order matches the write order across two pointer wraps.
- Reset asserted with level=5 while wen=1: next cycle level=0, rempty=1, overflow=0 and underflow=0, and the wdata from the reset cycle is not stored.
